// File: rtl/onchip_arb_pkg.sv
// onchip_arb_pkg: shared widths, constants and read-tag type
// for the on-chip memory arbiter slice.
package onchip_arb_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int BE_W = 4;
    localparam int ID_W = 3;
    localparam int RD_LATENCY = 2;
    localparam logic [DATA_W-1:0] BAD_RDATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic valid;
        logic [ID_W-1:0] id;
    } rd_tag_t;
endpackage

// File: rtl/onchip_rr_arbiter.sv
// onchip_rr_arbiter: round-robin pick starting after the last
// winner; combinational grant, registered pointer.
module onchip_rr_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] pending,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid
);
    logic [ID_W-1:0] ptr;

    // first pending index at or after ptr+1, wrapping
    always_comb begin
        grant = '0;
        grant_id = '0;
        grant_valid = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_valid && pending[i] &&
                    i == (int'(ptr) + k) % NUM_REQ) begin
                    grant_valid = 1'b1;
                    grant_id = ID_W'(i);
                    grant[i] = 1'b1;
                end
            end
        end
    end

    // remember the last winner so it goes to the back of the line
    always_ff @(posedge clk) begin
        if (!reset_n)
            ptr <= '0;
        else if (grant_valid)
            ptr <= grant_id;
    end
endmodule

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: N requesters share one single-port RAM.
// Optional macro ONCHIP_ARB_BOUNDS_CHECK_EN blocks out-of-range access.
module onchip_mem_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int MEM_DEPTH = 40000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*BE_W-1:0]   req_byteenable,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [DATA_W-1:0]         req_readdata,
    output logic [NUM_REQ-1:0]        req_readdatavalid,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [BE_W-1:0]           mem_byteenable,
    output logic                      mem_chipselect,
    output logic                      mem_write,
    output logic [DATA_W-1:0]         mem_writedata,
    output logic                      mem_clken,
`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
    output logic [NUM_REQ-1:0]        err_sticky,
`endif
    input  logic [DATA_W-1:0]         mem_readdata
);
    if (NUM_REQ < 2 || NUM_REQ > 8 ||
        MEM_DEPTH < 1 || MEM_DEPTH > 65536) begin : g_bad_cfg
        $error("onchip_mem_arbiter: bad NUM_REQ or MEM_DEPTH");
    end

    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win;
    logic               won;
    logic [ADDR_W-1:0]  sel_addr;
    logic [BE_W-1:0]    sel_be;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_wr;
    logic               sel_rd;
    logic               in_range;
    logic               oob_q;
    logic [DATA_W-1:0]  rdata_q;
    rd_tag_t            tag [RD_LATENCY];

    assign pending = (req_read | req_write) & {NUM_REQ{reset_n}};

    onchip_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .pending     (pending),
        .grant       (grant),
        .grant_id    (win),
        .grant_valid (won)
    );

    assign req_waitrequest = ~grant;

    // route the winner's request fields to the RAM side
    always_comb begin
        sel_addr = '0;
        sel_be = '0;
        sel_wdata = '0;
        sel_wr = 1'b0;
        sel_rd = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_address[i*ADDR_W +: ADDR_W];
                sel_be = req_byteenable[i*BE_W +: BE_W];
                sel_wdata = req_writedata[i*DATA_W +: DATA_W];
                sel_wr = req_write[i];
                sel_rd = req_read[i] & ~req_write[i];
            end
        end
    end

`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
    assign in_range = int'({16'b0, sel_addr}) < MEM_DEPTH;

    // flag reads that must return the poison word
    always_ff @(posedge clk) begin
        if (!reset_n)
            oob_q <= 1'b0;
        else
            oob_q <= sel_rd & ~in_range;
    end

    // latch which requester touched memory out of range
    always_ff @(posedge clk) begin
        if (!reset_n)
            err_sticky <= '0;
        else if (won && !in_range)
            err_sticky <= err_sticky | grant;
    end
`else
    assign in_range = 1'b1;
    assign oob_q = 1'b0;
`endif

    assign mem_address = sel_addr;
    assign mem_byteenable = sel_be;
    assign mem_writedata = sel_wdata;
    assign mem_chipselect = won & in_range;
    assign mem_write = sel_wr & in_range;
    assign mem_clken = 1'b1;

    // track accepted reads until their data is back
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LATENCY; i++)
                tag[i] <= '0;
        end else begin
            tag[0] <= '{valid: sel_rd, id: win};
            for (int i = 1; i < RD_LATENCY; i++)
                tag[i] <= tag[i-1];
        end
    end

    // register RAM q the cycle after the address was taken
    always_ff @(posedge clk) begin
        if (!reset_n)
            rdata_q <= '0;
        else if (tag[0].valid)
            rdata_q <= oob_q ? BAD_RDATA : mem_readdata;
    end

    assign req_readdata = reset_n ? rdata_q : '0;

    // one-hot return strobe for the owner of the oldest read
    always_comb begin
        req_readdatavalid = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_readdatavalid[i] = reset_n &&
                tag[RD_LATENCY-1].valid &&
                tag[RD_LATENCY-1].id == ID_W'(i);
    end

    // a requester must never read and write in the same cycle
    a_no_rd_wr: assert property (@(posedge clk) disable iff (!reset_n)
        (req_read & req_write) == '0)
        else $error("read and write asserted together");
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: scenario tasks plus random traffic
// checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_onchip_mem_arbiter;
    localparam int N = 2;
    localparam int DEPTH = 40000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [N*16-1:0] req_address = '0;
    logic [N*4-1:0] req_byteenable = '0;
    logic [N-1:0] req_read = '0;
    logic [N-1:0] req_write = '0;
    logic [N*32-1:0] req_writedata = '0;
    logic [N-1:0] req_waitrequest;
    logic [31:0] req_readdata;
    logic [N-1:0] req_readdatavalid;
    logic [15:0] mem_address;
    logic [3:0] mem_byteenable;
    logic mem_chipselect;
    logic mem_write;
    logic [31:0] mem_writedata;
    logic mem_clken;
    logic [31:0] mem_readdata;
`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
    logic [N-1:0] err_sticky;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onchip_mem_arbiter #(.NUM_REQ(N), .MEM_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_address       (req_address),
        .req_byteenable    (req_byteenable),
        .req_read          (req_read),
        .req_write         (req_write),
        .req_writedata     (req_writedata),
        .req_waitrequest   (req_waitrequest),
        .req_readdata      (req_readdata),
        .req_readdatavalid (req_readdatavalid),
        .mem_address       (mem_address),
        .mem_byteenable    (mem_byteenable),
        .mem_chipselect    (mem_chipselect),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_clken         (mem_clken),
`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
        .err_sticky        (err_sticky),
`endif
        .mem_readdata      (mem_readdata)
    );

    // attached RAM: 1-cycle read, byte-enabled write
    logic [31:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b])
                        ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    // reference model: pointer, memory image, pending returns
    typedef struct {
        int due;
        int id;
        logic [31:0] data;
    } ret_t;
    ret_t rq[$];
    int cyc = 0;
    int m_ptr = 0;
    logic [31:0] ref_mem [0:65535];
`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
    logic [N-1:0] m_err = '0;
`endif

    function automatic bit addr_ok(logic [15:0] a);
`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
        return int'(a) < DEPTH;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int pick();
        if (!reset_n) return -1;
        for (int k = 1; k <= N; k++) begin
            int i = (m_ptr + k) % N;
            if (req_read[i] || req_write[i]) return i;
        end
        return -1;
    endfunction

    function automatic void exp_ret(output logic [N-1:0] v,
                                    output logic [31:0] d);
        v = '0;
        d = '0;
        foreach (rq[j])
            if (rq[j].due == cyc) begin
                v[rq[j].id] = 1'b1;
                d = rq[j].data;
            end
    endfunction

    always @(posedge clk) begin
        int w;
        logic [15:0] a;
        ret_t r;
        if (!reset_n) begin
            m_ptr = 0;
            rq.delete();
`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
            m_err = '0;
`endif
        end else begin
            w = pick();
            while (rq.size() > 0 && rq[0].due <= cyc)
                void'(rq.pop_front());
            if (w >= 0) begin
                a = req_address[16*w +: 16];
                m_ptr = w;
`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
                if (!addr_ok(a)) m_err[w] = 1'b1;
`endif
                if (req_write[w]) begin
                    if (addr_ok(a))
                        for (int b = 0; b < 4; b++)
                            if (req_byteenable[4*w + b])
                                ref_mem[a][8*b +: 8] =
                                    req_writedata[32*w + 8*b +: 8];
                end else begin
                    r.due = cyc + 2;
                    r.id = w;
                    r.data = addr_ok(a) ? ref_mem[a] : 32'hDEAD_BEEF;
                    rq.push_back(r);
                end
            end
        end
        cyc++;
    end

    task automatic set_req(int i, bit rd, bit wr, logic [15:0] a,
                           logic [3:0] be, logic [31:0] d);
        req_read[i] = rd;
        req_write[i] = wr;
        req_address[16*i +: 16] = a;
        req_byteenable[4*i +: 4] = be;
        req_writedata[32*i +: 32] = d;
    endtask

    task automatic idle_all;
        req_read = '0;
        req_write = '0;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        set_req(0, 1, 0, 16'h3, 4'hF, 32'h0);
        set_req(1, 0, 1, 16'h4, 4'hF, 32'h55);
        @(negedge clk);
        checks++;
        if (req_waitrequest !== 2'b11) begin
            errors++;
            $display("FAIL rst_wait got %b want 11", req_waitrequest);
        end
        checks++;
        if (req_readdatavalid !== 2'b00) begin
            errors++;
            $display("FAIL rst_rdv got %b want 00", req_readdatavalid);
        end
        checks++;
        if (mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_cs got cs=%b wr=%b want 0 0",
                     mem_chipselect, mem_write);
        end
        checks++;
        if (req_readdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_rdata got %h want 0", req_readdata);
        end
        checks++;
        if (mem_clken !== 1'b1) begin
            errors++;
            $display("FAIL rst_clken got %b want 1", mem_clken);
        end
        next_cycle;
        idle_all;
        next_cycle;
        reset_n = 1'b1;
        next_cycle;
    endtask

    task automatic preload;
        for (int a = 0; a < 32; a++) begin
            set_req(0, 0, 1, 16'(a), 4'hF, $urandom);
            next_cycle;
        end
        idle_all;
        next_cycle;
    endtask

    task automatic test_write_readback;
        set_req(0, 0, 1, 16'h0010, 4'hF, 32'hA5A5_1234);
        @(negedge clk);
        checks++;
        if (req_waitrequest !== 2'b10 || mem_write !== 1'b1 ||
            mem_chipselect !== 1'b1) begin
            errors++;
            $display("FAIL wr_accept got wait=%b wr=%b cs=%b want 10 1 1",
                     req_waitrequest, mem_write, mem_chipselect);
        end
        checks++;
        if (mem_address !== 16'h0010 || mem_writedata !== 32'hA5A5_1234) begin
            errors++;
            $display("FAIL wr_fields got %h/%h want 0010/a5a51234",
                     mem_address, mem_writedata);
        end
        next_cycle;
        set_req(0, 1, 0, 16'h0010, 4'hF, 32'h0);
        @(negedge clk);
        checks++;
        if (req_waitrequest[0] !== 1'b0 || mem_write !== 1'b0 ||
            mem_chipselect !== 1'b1) begin
            errors++;
            $display("FAIL rd_accept got wait=%b wr=%b cs=%b want x0 0 1",
                     req_waitrequest, mem_write, mem_chipselect);
        end
        next_cycle;
        idle_all;
        @(negedge clk);
        checks++;
        if (req_readdatavalid !== 2'b00) begin
            errors++;
            $display("FAIL rd_lat1 got %b want 00", req_readdatavalid);
        end
        next_cycle;
        @(negedge clk);
        checks++;
        if (req_readdatavalid !== 2'b01 || req_readdata !== 32'hA5A5_1234) begin
            errors++;
            $display("FAIL rd_lat2 got %b/%h want 01/a5a51234",
                     req_readdatavalid, req_readdata);
        end
        next_cycle;
        @(negedge clk);
        checks++;
        if (req_readdatavalid !== 2'b00) begin
            errors++;
            $display("FAIL rd_lat3 got %b want 00", req_readdatavalid);
        end
        next_cycle;
    endtask

    task automatic test_byte_enables;
        set_req(0, 0, 1, 16'd5, 4'hF, 32'hFFFF_FFFF);
        next_cycle;
        set_req(0, 0, 1, 16'd5, 4'b0101, 32'h0000_0000);
        @(negedge clk);
        checks++;
        if (mem_byteenable !== 4'b0101) begin
            errors++;
            $display("FAIL be_pass got %b want 0101", mem_byteenable);
        end
        next_cycle;
        set_req(0, 1, 0, 16'd5, 4'hF, 32'h0);
        next_cycle;
        idle_all;
        next_cycle;
        @(negedge clk);
        checks++;
        if (req_readdatavalid !== 2'b01 || req_readdata !== 32'hFF00_FF00) begin
            errors++;
            $display("FAIL be_merge got %b/%h want 01/ff00ff00",
                     req_readdatavalid, req_readdata);
        end
        next_cycle;
    endtask

    task automatic test_contention;
        logic [N-1:0] ew;
        logic [N-1:0] ev;
        logic [31:0] ed;
        set_req(0, 0, 1, 16'd1, 4'hF, 32'h1111_1111);
        next_cycle;
        set_req(0, 0, 1, 16'd2, 4'hF, 32'h2222_2222);
        next_cycle;
        idle_all;
        reset_n = 1'b0;
        next_cycle;
        next_cycle;
        reset_n = 1'b1;
        set_req(0, 1, 0, 16'd1, 4'hF, 32'h0);
        set_req(1, 1, 0, 16'd2, 4'hF, 32'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            ew = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (req_waitrequest !== ew) begin
                errors++;
                $display("FAIL cont_wait[%0d] got %b want %b",
                         k, req_waitrequest, ew);
            end
            ev = (k < 2) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01);
            ed = (k % 2 == 0) ? 32'h2222_2222 : 32'h1111_1111;
            checks++;
            if (req_readdatavalid !== ev ||
                (ev != 2'b00 && req_readdata !== ed)) begin
                errors++;
                $display("FAIL cont_ret[%0d] got %b/%h want %b/%h",
                         k, req_readdatavalid, req_readdata, ev, ed);
            end
            next_cycle;
        end
        idle_all;
        repeat (3) next_cycle;
    endtask

    task automatic test_simul_wr_rd;
        for (int rep = 0; rep < 2; rep++) begin
            logic [31:0] oldv;
            logic [31:0] newv;
            logic [31:0] ed;
            logic [N-1:0] ew;
            logic [N-1:0] acc;
            int first;
            bit got;
            set_req(rep, 1, 0, 16'd7, 4'hF, 32'h0);
            next_cycle;
            idle_all;
            repeat (3) next_cycle;
            oldv = ref_mem[7];
            newv = ~oldv;
            set_req(0, 0, 1, 16'd7, 4'hF, newv);
            set_req(1, 1, 0, 16'd7, 4'hF, 32'h0);
            first = pick();
            ed = (first == 0) ? newv : oldv;
            ew = (first == 0) ? 2'b10 : 2'b01;
            got = 1'b0;
            for (int k = 0; k < 8 && !got; k++) begin
                @(negedge clk);
                if (k == 0) begin
                    checks++;
                    if (req_waitrequest !== ew) begin
                        errors++;
                        $display("FAIL simul_grant[%0d] got %b want %b",
                                 rep, req_waitrequest, ew);
                    end
                end
                if (req_readdatavalid[1]) begin
                    got = 1'b1;
                    checks++;
                    if (req_readdata !== ed) begin
                        errors++;
                        $display("FAIL simul_data[%0d] got %h want %h",
                                 rep, req_readdata, ed);
                    end
                end
                acc = ~req_waitrequest;
                next_cycle;
                if (acc[0]) req_write[0] = 1'b0;
                if (acc[1]) req_read[1] = 1'b0;
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL simul_timeout[%0d] got none want rdv[1]", rep);
            end
            idle_all;
            repeat (3) next_cycle;
        end
    endtask

    task automatic test_reset_mid_read;
        set_req(0, 1, 0, 16'h0010, 4'hF, 32'h0);
        @(negedge clk);
        checks++;
        if (req_waitrequest[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_accept got %b want x0", req_waitrequest);
        end
        next_cycle;
        reset_n = 1'b0;
        idle_all;
        set_req(1, 1, 0, 16'h0010, 4'hF, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (req_readdatavalid !== 2'b00 || req_waitrequest !== 2'b11 ||
                mem_chipselect !== 1'b0 || req_readdata !== 32'h0) begin
                errors++;
                $display("FAIL mid_rst[%0d] got rdv=%b wait=%b cs=%b rd=%h want 00 11 0 0",
                         k, req_readdatavalid, req_waitrequest,
                         mem_chipselect, req_readdata);
            end
            next_cycle;
        end
        reset_n = 1'b1;
        idle_all;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (req_readdatavalid !== 2'b00) begin
                errors++;
                $display("FAIL mid_stale[%0d] got %b want 00",
                         k, req_readdatavalid);
            end
            next_cycle;
        end
        set_req(1, 1, 0, 16'h0010, 4'hF, 32'h0);
        next_cycle;
        idle_all;
        next_cycle;
        @(negedge clk);
        checks++;
        if (req_readdatavalid !== 2'b10 || req_readdata !== 32'hA5A5_1234) begin
            errors++;
            $display("FAIL mid_after got %b/%h want 10/a5a51234",
                     req_readdatavalid, req_readdata);
        end
        next_cycle;
    endtask

    task automatic test_random;
        bit act [N];
        bit wr [N];
        logic [15:0] ad [N];
        logic [3:0] be [N];
        logic [31:0] wd [N];
        logic [N-1:0] acc;
        logic [N-1:0] ew;
        logic [N-1:0] ev;
        logic [31:0] ed;
        int w;
        for (int i = 0; i < N; i++) act[i] = 1'b0;
        acc = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!act[i] || acc[i]) begin
                    act[i] = ($urandom % 100) < 60;
                    wr[i] = $urandom % 2;
                    ad[i] = 16'($urandom % 32);
                    be[i] = 4'($urandom);
                    wd[i] = $urandom;
                end else if (($urandom % 100) < 10) begin
                    act[i] = 1'b0;
                end
                set_req(i, act[i] & ~wr[i], act[i] & wr[i], ad[i], be[i], wd[i]);
            end
            @(negedge clk);
            w = pick();
            acc = '0;
            if (w >= 0) acc[w] = 1'b1;
            ew = ~acc;
            checks++;
            if (req_waitrequest !== ew) begin
                errors++;
                $display("FAIL rnd_wait[%0d] got %b want %b",
                         c, req_waitrequest, ew);
            end
            if (w >= 0) begin
                checks++;
                if (mem_chipselect !== 1'b1 || mem_address !== ad[w] ||
                    mem_write !== wr[w] ||
                    (wr[w] && (mem_writedata !== wd[w] ||
                               mem_byteenable !== be[w]))) begin
                    errors++;
                    $display("FAIL rnd_mem[%0d] got cs=%b a=%h w=%b d=%h be=%b want 1 %h %b %h %b",
                             c, mem_chipselect, mem_address, mem_write,
                             mem_writedata, mem_byteenable,
                             ad[w], wr[w], wd[w], be[w]);
                end
            end
            exp_ret(ev, ed);
            checks++;
            if (req_readdatavalid !== ev ||
                (ev != '0 && req_readdata !== ed)) begin
                errors++;
                $display("FAIL rnd_ret[%0d] got %b/%h want %b/%h",
                         c, req_readdatavalid, req_readdata, ev, ed);
            end
            next_cycle;
        end
        idle_all;
        repeat (3) next_cycle;
    endtask

`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
    task automatic test_bounds;
        set_req(1, 0, 1, 16'd40000, 4'hF, 32'h1);
        @(negedge clk);
        checks++;
        if (req_waitrequest !== 2'b01 || mem_chipselect !== 1'b0 ||
            mem_write !== 1'b0) begin
            errors++;
            $display("FAIL oob_wr got wait=%b cs=%b wr=%b want 01 0 0",
                     req_waitrequest, mem_chipselect, mem_write);
        end
        next_cycle;
        set_req(1, 1, 0, 16'd40000, 4'hF, 32'h0);
        @(negedge clk);
        checks++;
        if (req_waitrequest !== 2'b01 || mem_chipselect !== 1'b0) begin
            errors++;
            $display("FAIL oob_rd got wait=%b cs=%b want 01 0",
                     req_waitrequest, mem_chipselect);
        end
        next_cycle;
        idle_all;
        next_cycle;
        @(negedge clk);
        checks++;
        if (req_readdatavalid !== 2'b10 || req_readdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL oob_ret got %b/%h want 10/deadbeef",
                     req_readdatavalid, req_readdata);
        end
        checks++;
        if (err_sticky !== 2'b10 || err_sticky !== m_err) begin
            errors++;
            $display("FAIL oob_err got %b want 10", err_sticky);
        end
        next_cycle;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        next_cycle;
        next_cycle;
        test_reset;
        preload;
        test_write_readback;
        test_byte_enables;
        test_contention;
        test_simul_wr_rd;
        test_reset_mid_read;
        test_random;
`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
        test_bounds;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
Shares one single-port 32-bit on-chip RAM (16-bit word address, 4-bit byteenable, 1-cycle read latency at the RAM pins) between NUM_REQ Avalon-MM-style requesters. Round-robin arbitration grants at most one access per cycle. Each requester gets waitrequest/readdatavalid semantics with a fixed read latency. It sits between the Qsys interconnect masters and the on-chip memory instance.

Parameters:
NUM_REQ, 2, number of requester ports (2..8)
MEM_DEPTH, 40000, valid word count of the attached RAM (used only by the optional bounds check)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
req_address  in  NUM_REQ*16  word address per requester, requester i at [16i+15:16i]
req_byteenable  in  NUM_REQ*4  byte enables per requester
req_read  in  NUM_REQ  read request, held until accepted
req_write  in  NUM_REQ  write request, held until accepted
req_writedata  in  NUM_REQ*32  write data per requester
req_waitrequest  out  NUM_REQ  high = request not accepted this cycle
req_readdata  out  32  shared read data bus, qualified per requester by readdatavalid
req_readdatavalid  out  NUM_REQ  one-hot pulse, read data for requester i
mem_address  out  16  to RAM address
mem_byteenable  out  4  to RAM byteenable
mem_chipselect  out  1  to RAM chipselect
mem_write  out  1  to RAM write
mem_writedata  out  32  to RAM writedata
mem_clken  out  1  to RAM clken; constant 1
mem_readdata  in  32  from RAM q, unregistered, valid the cycle after address is sampled

Behaviour:
- Reset is synchronous, active-low (reset_n): the round-robin pointer goes to requester 0 and the read-return pipeline is cleared. req_readdatavalid=0, req_readdata=0, and mem_chipselect=mem_write=0 while reset_n=0. req_waitrequest is all-ones during reset. mem_clken=1 always.
- Request i is pending when req_read[i]|req_write[i]. The winner is the first pending index at or after ptr+1 (mod NUM_REQ). The pick is combinational from the current requests.
- Accept cycle t: winner's req_waitrequest=0, all others 1. The mem_* outputs carry the winner's address, byteenable, writedata and write, with chipselect=1. With no pending request, chipselect=0 and write=0.
- ptr is updated to the winner index at the end of every accepted cycle; otherwise it holds.
- Write: completes at accept and has no response.
- Read: RAM q is valid in cycle t+1 and is registered into req_readdata. req_readdatavalid[winner]=1 in cycle t+2 only (fixed latency 2).
- Pipeline: a 2-stage {valid, id} shift register tracks reads in flight. Throughput is one access per cycle, so back-to-back reads from different requesters return in order on consecutive cycles.
- Read and write asserted together by one requester is illegal: write takes precedence, the read is dropped, and a simulation assertion fires.
- A requester deasserting its request while waitrequest=1 is legal; it simply loses its slot.
- Reset mid-operation: in-flight reads are discarded with no readdatavalid. RAM contents are untouched.
- Fairness: with all requesters continuously pending, each is granted exactly once every NUM_REQ cycles.

Optional Feature:
ONCHIP_ARB_BOUNDS_CHECK_EN
- Defined: an accepted access with address >= MEM_DEPTH drives mem_chipselect=0 and mem_write=0. A read still returns at latency 2, with req_readdata=32'hDEAD_BEEF. An extra output err_sticky[NUM_REQ] sets the bit for the offending requester; it is cleared only by reset.
- Undefined: addresses pass through unchecked, and the err_sticky port does not exist.

Decomposition:
- Package onchip_arb_pkg: ADDR_W=16, DATA_W=32, BE_W=4, RD_LATENCY=2, BAD_RDATA=32'hDEAD_BEEF, and the rd_tag_t struct {valid, id}.
- Sub-module onchip_rr_arbiter: holds the pending vector, ptr register and one-hot grant. It is parameterised by NUM_REQ and verified standalone.

Test Plan:
- Single write/readback: r0 writes 0xA5A5_1234 to addr 0x0010 (be=4'hF), then reads it. Expect waitrequest=0 at accept and readdatavalid[0] exactly 2 cycles later with 0xA5A5_1234.
- Byte enables: write 0xFFFF_FFFF, then 0x0000_0000 with be=4'b0101 to addr 5. Read returns 0xFF00_FF00.
- Contention: r0 and r1 read continuously from addrs 1 and 2. Grants alternate r1, r0, r1, and so on from reset (ptr=0). readdatavalid alternates one-hot and never overlaps.
- Simultaneous write/read: r0 writes addr 7 while r1 reads addr 7 in the same cycle. The order follows ptr; r1 sees old or new data consistent with the grant order.
- Reset mid-read: read accepted, reset_n=0 the next cycle. No readdatavalid appears and waitrequest is all-ones. After release, r1 reads old data intact.
- ONCHIP_ARB_BOUNDS_CHECK_EN: r1 writes 0x1 to addr 40000, then reads addr 40000. mem_chipselect stays 0, the read returns 0xDEAD_BEEF at latency 2, and err_sticky=2'b10.
